// File: rtl/sign_narrow_pkg.sv
// Shared definitions for the signed-word narrowing stage: default widths,
// saturation patterns, a representability helper and the occupancy states.
package sign_narrow_pkg;

  localparam int WIDE_DEF   = 32;
  localparam int NARROW_DEF = 16;

  localparam logic [NARROW_DEF-1:0] SAT_MAX = {1'b0, {(NARROW_DEF-1){1'b1}}};
  localparam logic [NARROW_DEF-1:0] SAT_MIN = {1'b1, {(NARROW_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } occ_e;

  // A word fits when every dropped bit and the kept MSB agree with the sign.
  function automatic logic fits_narrow(logic [WIDE_DEF-1:0] word);
    logic [WIDE_DEF-NARROW_DEF:0] top;
    top = word[WIDE_DEF-1:NARROW_DEF-1];
    return (&top) || !(|top);
  endfunction

endpackage

// File: rtl/sign_narrow_calc.sv
// Combinational narrowing: overflow detection plus wrap or saturate result.
module narrow_calc
  import sign_narrow_pkg::*;
#(
  parameter int WIDE   = 32,
  parameter int NARROW = 16
) (
  input  logic [WIDE-1:0]   data_i,
  input  logic              sat_i,
  output logic [NARROW-1:0] res_o,
  output logic              ovf_o
);

  logic [WIDE-NARROW:0] top;

  function automatic logic [NARROW-1:0] sat_pick(logic neg);
    return neg ? {1'b1, {(NARROW-1){1'b0}}} : {1'b0, {(NARROW-1){1'b1}}};
  endfunction

  assign top   = data_i[WIDE-1:NARROW-1];
  assign ovf_o = !(&top) && (|top);

  always_comb begin
    res_o = data_i[NARROW-1:0];
    if (sat_i && ovf_o) res_o = sat_pick(data_i[WIDE-1]);
  end

endmodule

// File: rtl/sign_narrow.sv
// Narrows a signed WIDE-bit word to NARROW bits behind a valid/ready
// handshake with a one-entry skid buffer and overflow tracking.
module sign_narrow
  import sign_narrow_pkg::*;
#(
  parameter int WIDE   = 32,
  parameter int NARROW = 16,
  parameter int CNTW   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDE-1:0]   in_data,
  input  logic              in_sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NARROW-1:0] out_data,
  output logic              out_ovf,
  output logic              ovf_sticky,
  output logic [CNTW-1:0]   ovf_count,
  input  logic              clr_ovf
);

  occ_e              state_q;
  logic              in_ready_q, out_valid_q;
  logic [WIDE-1:0]   skid_data_q;
  logic              skid_sat_q;
  logic [NARROW-1:0] out_data_q;
  logic              out_ovf_q, sticky_q;
  logic [CNTW-1:0]   count_q;

  logic              in_xfer, out_xfer, skid_full, load_out, skid_load;
  logic [WIDE-1:0]   calc_data_d;
  logic              calc_sat_d;
  logic [NARROW-1:0] res_d;
  logic              ovf_d;

  assign in_xfer   = in_valid && in_ready_q;
  assign out_xfer  = out_valid_q && out_ready;
  assign skid_full = (state_q == TWO);
  // A full buffer always has priority; the input cannot transfer in that state.
  assign load_out  = skid_full ? out_xfer : (in_xfer && (!out_valid_q || out_xfer));
  assign skid_load = in_xfer && out_valid_q && !out_xfer;

  assign calc_data_d = skid_full ? skid_data_q : in_data;
  assign calc_sat_d  = skid_full ? skid_sat_q  : in_sat;

  narrow_calc #(.WIDE(WIDE), .NARROW(NARROW)) u_calc (
    .data_i (calc_data_d),
    .sat_i  (calc_sat_d),
    .res_o  (res_d),
    .ovf_o  (ovf_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      if (load_out) begin
        out_data_q <= res_d;
        out_ovf_q  <= ovf_d;
      end
      case (state_q)
        EMPTY: if (in_xfer) begin
          state_q     <= ONE;
          out_valid_q <= 1'b1;
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            state_q    <= TWO;
            in_ready_q <= 1'b0;
          end else if (!in_xfer && out_xfer) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        TWO: if (out_xfer) begin
          state_q    <= ONE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_data_q <= in_data;
      skid_sat_q  <= in_sat;
    end
  end

  // Clear wins over a same-cycle overflow event, which is then lost.
  always_ff @(posedge clk) begin
    if (reset || clr_ovf) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else if (out_xfer && out_ovf_q) begin
      sticky_q <= 1'b1;
      if (count_q != {CNTW{1'b1}}) count_q <= count_q + 1'b1;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ovf    = out_ovf_q;
  assign ovf_sticky = sticky_q;
  assign ovf_count  = count_q;

endmodule
